// File: rtl/cp0_ctrl_pkg.sv
// Shared CP0 definitions: exception codes, register selects, write masks and
// the exported register-file view.
package cp0_ctrl_pkg;

  typedef enum logic [4:0] {
    INT  = 5'd0,
    MOD  = 5'd1,
    TLBL = 5'd2,
    TLBS = 5'd3,
    ADEL = 5'd4,
    ADES = 5'd5,
    IBE  = 5'd6,
    DBE  = 5'd7,
    SYS  = 5'd8,
    BP   = 5'd9,
    RI   = 5'd10,
    CPU  = 5'd11,
    OV   = 5'd12,
    TR   = 5'd13
  } ecode_t;

  // Selects are {rd[4:0], sel[2:0]}.
  localparam logic [7:0] RS_BADVADDR = {5'd8,  3'd0};
  localparam logic [7:0] RS_COUNT    = {5'd9,  3'd0};
  localparam logic [7:0] RS_COMPARE  = {5'd11, 3'd0};
  localparam logic [7:0] RS_STATUS   = {5'd12, 3'd0};
  localparam logic [7:0] RS_CAUSE    = {5'd13, 3'd0};
  localparam logic [7:0] RS_EPC      = {5'd14, 3'd0};

  localparam logic [31:0] CP0_STATUS_MASK = 32'h0000_FF03;
  localparam logic [31:0] CP0_CAUSE_MASK  = 32'h0000_0300;

  typedef struct packed {
    logic [31:0] badvaddr;
    logic [31:0] count;
    logic [31:0] compare;
    logic [31:0] status;
    logic [31:0] cause;
    logic [31:0] epc;
  } cp0_regfile_t;

  function automatic logic [31:0] apply_mask(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [31:0] mask);
    return (old_v & ~mask) | (new_v & mask);
  endfunction

  function automatic logic is_addr_err(input ecode_t c);
    return (c == ADEL) || (c == ADES);
  endfunction

endpackage

// File: rtl/cp0_ctrl_if.sv
// Bundle of the CP0 lane, exception and read-back signals for the pipeline side.
interface cp0_ctrl_if import cp0_ctrl_pkg::*; #(
  parameter int unsigned NPORT  = 2,
  parameter int unsigned NHWINT = 5
) ();

  logic [NHWINT-1:0]           ext_int;
  logic [NPORT-1:0]            wen;
  logic [NPORT-1:0][7:0]       wsel;
  logic [NPORT-1:0][31:0]      wdata;
  logic [NPORT-1:0]            exc_valid;
  ecode_t [NPORT-1:0]          exc_code;
  logic [NPORT-1:0][31:0]      exc_pc;
  logic [NPORT-1:0]            exc_bd;
  logic [NPORT-1:0][31:0]      exc_badvaddr;
  logic                        eret;
  logic [7:0]                  rsel;
  logic [31:0]                 rdata;
  logic                        cp0_flush;
  logic [31:0]                 epc_out;
  logic                        int_pending;
  cp0_regfile_t                cp0_reg;

  modport master (
    output ext_int, wen, wsel, wdata, exc_valid, exc_code, exc_pc, exc_bd,
           exc_badvaddr, eret, rsel,
    input  rdata, cp0_flush, epc_out, int_pending, cp0_reg
  );

  modport slave (
    input  ext_int, wen, wsel, wdata, exc_valid, exc_code, exc_pc, exc_bd,
           exc_badvaddr, eret, rsel,
    output rdata, cp0_flush, epc_out, int_pending, cp0_reg
  );

endinterface

// File: rtl/cp0_ctrl_timer.sv
// Count/Compare timer with prescaler and sticky timer-interrupt flag.
module cp0_timer #(
  parameter int unsigned TIMER_DIV = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        cnt_we_i,
  input  logic [31:0] cnt_wd_i,
  input  logic        cmp_we_i,
  input  logic [31:0] cmp_wd_i,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic        ti_o
);

  localparam int unsigned PW = (TIMER_DIV > 1) ? $clog2(TIMER_DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(TIMER_DIV - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic [31:0]   count_q, count_d;
  logic [31:0]   compare_q, compare_d;
  logic          ti_q, ti_d;
  logic          tick;

  always_comb begin
    tick      = (presc_q == PMAX);
    presc_d   = tick ? '0 : presc_q + 1'b1;
    count_d   = tick ? count_q + 32'd1 : count_q;
    if (cnt_we_i) begin
      count_d = cnt_wd_i;
      presc_d = '0;
    end
    compare_d = cmp_we_i ? cmp_wd_i : compare_q;
    // Compare write clears TI even when the old values match this cycle.
    ti_d      = cmp_we_i ? 1'b0 : (ti_q | (count_q == compare_q));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      presc_q   <= '0;
      count_q   <= '0;
      compare_q <= '0;
      ti_q      <= 1'b0;
    end else begin
      presc_q   <= presc_d;
      count_q   <= count_d;
      compare_q <= compare_d;
      ti_q      <= ti_d;
    end
  end

  assign count_o   = count_q;
  assign compare_o = compare_q;
  assign ti_o      = ti_q;

endmodule

// File: rtl/cp0_ctrl.sv
// MIPS-style CP0: multi-lane MTC0 writes, precise exception entry, ERET,
// interrupt synchronisation and pending-interrupt generation.
module cp0_ctrl import cp0_ctrl_pkg::*; #(
  parameter int unsigned NPORT       = 2,
  parameter int unsigned TIMER_DIV   = 2,
  parameter int unsigned NHWINT      = 5,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [NHWINT-1:0]      ext_int,
  input  logic [NPORT-1:0]       wen,
  input  logic [NPORT-1:0][7:0]  wsel,
  input  logic [NPORT-1:0][31:0] wdata,
  input  logic [NPORT-1:0]       exc_valid,
  input  ecode_t [NPORT-1:0]     exc_code,
  input  logic [NPORT-1:0][31:0] exc_pc,
  input  logic [NPORT-1:0]       exc_bd,
  input  logic [NPORT-1:0][31:0] exc_badvaddr,
  input  logic                   eret,
  input  logic [7:0]             rsel,
  output logic [31:0]            rdata,
  output logic                   cp0_flush,
  output logic [31:0]            epc_out,
  output logic                   int_pending,
  output cp0_regfile_t           cp0_reg
);

  logic [31:0] badvaddr_q, badvaddr_d;
  logic [31:0] status_q, status_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] cause_wr_q, cause_wr_d;
  logic        cause_bd_q, cause_bd_d;
  ecode_t      cause_code_q, cause_code_d;

  logic [SYNC_STAGES-1:0][NHWINT-1:0] sync_q;

  logic             found, accept;
  logic [NPORT-1:0] lane_ok;
  ecode_t           acc_code;
  logic [31:0]      acc_pc, acc_bva;
  logic             acc_bd;

  logic        cnt_we, cmp_we;
  logic [31:0] cnt_wd, cmp_wd;
  logic [31:0] count, compare;
  logic        ti;
  logic [5:0]  ip_hw;
  logic [31:0] cause_word;

  cp0_timer #(.TIMER_DIV(TIMER_DIV)) u_timer (
    .clk_i    (clk),
    .rst_ni   (resetn),
    .cnt_we_i (cnt_we),
    .cnt_wd_i (cnt_wd),
    .cmp_we_i (cmp_we),
    .cmp_wd_i (cmp_wd),
    .count_o  (count),
    .compare_o(compare),
    .ti_o     (ti)
  );

  // A lane may write only if no exception was accepted at or below its index.
  always_comb begin
    found    = 1'b0;
    lane_ok  = '0;
    acc_code = INT;
    acc_pc   = '0;
    acc_bva  = '0;
    acc_bd   = 1'b0;
    for (int unsigned i = 0; i < NPORT; i++) begin
      if (exc_valid[i] && !status_q[1] && !found) begin
        found    = 1'b1;
        acc_code = exc_code[i];
        acc_pc   = exc_pc[i];
        acc_bva  = exc_badvaddr[i];
        acc_bd   = exc_bd[i];
      end
      lane_ok[i] = !found;
    end
    accept = found & resetn;
  end

  // Priority low to high: eret, MTC0 lanes in order, exception entry.
  always_comb begin
    status_d     = status_q;
    epc_d        = epc_q;
    badvaddr_d   = badvaddr_q;
    cause_wr_d   = cause_wr_q;
    cause_bd_d   = cause_bd_q;
    cause_code_d = cause_code_q;
    cnt_we       = 1'b0;
    cnt_wd       = '0;
    cmp_we       = 1'b0;
    cmp_wd       = '0;
    if (eret) status_d[1] = 1'b0;
    for (int unsigned i = 0; i < NPORT; i++) begin
      if (wen[i] && lane_ok[i]) begin
        case (wsel[i])
          RS_STATUS:   status_d   = apply_mask(status_d, wdata[i], CP0_STATUS_MASK);
          RS_CAUSE:    cause_wr_d = apply_mask(cause_wr_d, wdata[i], CP0_CAUSE_MASK);
          RS_EPC:      epc_d      = wdata[i];
          RS_BADVADDR: badvaddr_d = wdata[i];
          RS_COUNT: begin
            cnt_we = 1'b1;
            cnt_wd = wdata[i];
          end
          RS_COMPARE: begin
            cmp_we = 1'b1;
            cmp_wd = wdata[i];
          end
          default: ;
        endcase
      end
    end
    if (accept) begin
      epc_d        = acc_bd ? acc_pc - 32'd4 : acc_pc;
      cause_bd_d   = acc_bd;
      cause_code_d = acc_code;
      status_d[1]  = 1'b1;
      if (is_addr_err(acc_code)) badvaddr_d = acc_bva;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      badvaddr_q   <= '0;
      status_q     <= '0;
      epc_q        <= '0;
      cause_wr_q   <= '0;
      cause_bd_q   <= 1'b0;
      cause_code_q <= INT;
    end else begin
      badvaddr_q   <= badvaddr_d;
      status_q     <= status_d;
      epc_q        <= epc_d;
      cause_wr_q   <= cause_wr_d;
      cause_bd_q   <= cause_bd_d;
      cause_code_q <= cause_code_d;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= ext_int;
      for (int unsigned s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  always_comb begin
    ip_hw              = '0;
    ip_hw[NHWINT-1:0]  = sync_q[SYNC_STAGES-1];
    ip_hw[5]           = ti;
    cause_word         = cause_wr_q;
    cause_word[31]     = cause_bd_q;
    cause_word[15:10]  = ip_hw;
    cause_word[6:2]    = cause_code_q;
  end

  always_comb begin
    case (rsel)
      RS_BADVADDR: rdata = badvaddr_q;
      RS_COUNT:    rdata = count;
      RS_COMPARE:  rdata = compare;
      RS_STATUS:   rdata = status_q;
      RS_CAUSE:    rdata = cause_word;
      RS_EPC:      rdata = epc_q;
      default:     rdata = '0;
    endcase
  end

  always_comb begin
    cp0_reg.badvaddr = badvaddr_q;
    cp0_reg.count    = count;
    cp0_reg.compare  = compare;
    cp0_reg.status   = status_q;
    cp0_reg.cause    = cause_word;
    cp0_reg.epc      = epc_q;
  end

  assign cp0_flush   = accept;
  assign epc_out     = epc_q;
  assign int_pending = status_q[0] & ~status_q[1] & |(cause_word[15:8] & status_q[15:8]);

endmodule

// File: tb/tb_cp0_ctrl.sv
// Randomised and directed bench for cp0_ctrl against an architectural model.
module tb_cp0_ctrl;
  import cp0_ctrl_pkg::*;

  localparam int NPORT       = 2;
  localparam int TIMER_DIV   = 2;
  localparam int NHWINT      = 5;
  localparam int SYNC_STAGES = 2;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  cp0_ctrl_if #(.NPORT(NPORT), .NHWINT(NHWINT)) bus ();

  cp0_ctrl #(
    .NPORT(NPORT), .TIMER_DIV(TIMER_DIV), .NHWINT(NHWINT), .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk(clk), .resetn(resetn), .ext_int(bus.ext_int), .wen(bus.wen),
    .wsel(bus.wsel), .wdata(bus.wdata), .exc_valid(bus.exc_valid),
    .exc_code(bus.exc_code), .exc_pc(bus.exc_pc), .exc_bd(bus.exc_bd),
    .exc_badvaddr(bus.exc_badvaddr), .eret(bus.eret), .rsel(bus.rsel),
    .rdata(bus.rdata), .cp0_flush(bus.cp0_flush), .epc_out(bus.epc_out),
    .int_pending(bus.int_pending), .cp0_reg(bus.cp0_reg)
  );

  int total = 0;
  int bad   = 0;

  // Architectural model: Count is base value plus elapsed cycles / TIMER_DIV.
  logic [31:0] m_bva, m_cmp, m_status, m_epc, m_cause_sw, m_cnt_base;
  int unsigned m_elapsed;
  logic        m_bd, m_ti;
  logic [4:0]  m_code;
  logic [NHWINT-1:0] m_hist[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_count_now();
    return m_cnt_base + 32'(m_elapsed / TIMER_DIV);
  endfunction

  function automatic logic [31:0] exp_cause();
    logic [31:0] w;
    logic [NHWINT-1:0] hw;
    w  = m_cause_sw;
    hw = m_hist[SYNC_STAGES-1];
    w[31] = m_bd;
    w[15] = m_ti;
    for (int i = 0; i < NHWINT; i++) w[10+i] = hw[i];
    w[6:2] = m_code;
    return w;
  endfunction

  task automatic model_reset();
    m_bva = '0; m_cmp = '0; m_status = '0; m_epc = '0; m_cause_sw = '0;
    m_cnt_base = '0; m_elapsed = 0; m_bd = 1'b0; m_ti = 1'b0; m_code = '0;
    m_hist.delete();
    for (int s = 0; s < SYNC_STAGES; s++) m_hist.push_back('0);
  endtask

  task automatic model_update();
    int acc;
    logic [31:0] old_cnt, old_cmp, d, cnt_val;
    bit cnt_wr, cmp_wr;
    acc = -1; cnt_wr = 0; cmp_wr = 0; cnt_val = '0;
    old_cnt = m_count_now();
    old_cmp = m_cmp;
    if (!m_status[1])
      for (int i = 0; i < NPORT; i++) if (acc < 0 && bus.exc_valid[i]) acc = i;
    if (bus.eret) m_status[1] = 1'b0;
    for (int i = 0; i < NPORT; i++) begin
      if (bus.wen[i] && (acc < 0 || i < acc)) begin
        d = bus.wdata[i];
        case (bus.wsel[i])
          RS_STATUS:   m_status   = (m_status & ~CP0_STATUS_MASK) | (d & CP0_STATUS_MASK);
          RS_CAUSE:    m_cause_sw = d & CP0_CAUSE_MASK;
          RS_EPC:      m_epc      = d;
          RS_BADVADDR: m_bva      = d;
          RS_COUNT:    begin cnt_wr = 1; cnt_val = d; end
          RS_COMPARE:  begin cmp_wr = 1; m_cmp = d; end
          default: ;
        endcase
      end
    end
    if (acc >= 0) begin
      m_epc       = bus.exc_bd[acc] ? bus.exc_pc[acc] - 32'd4 : bus.exc_pc[acc];
      m_bd        = bus.exc_bd[acc];
      m_code      = bus.exc_code[acc];
      m_status[1] = 1'b1;
      if (bus.exc_code[acc] == ADEL || bus.exc_code[acc] == ADES) m_bva = bus.exc_badvaddr[acc];
    end
    m_ti = cmp_wr ? 1'b0 : (m_ti | (old_cnt == old_cmp));
    if (cnt_wr) begin
      m_cnt_base = cnt_val;
      m_elapsed  = 0;
    end else begin
      m_elapsed++;
    end
    m_hist.push_front(bus.ext_int);
    void'(m_hist.pop_back());
  endtask

  task automatic check_all();
    cp0_regfile_t r;
    logic [31:0] ca, rd;
    r  = bus.cp0_reg;
    ca = exp_cause();
    chk("badvaddr", r.badvaddr, m_bva);
    chk("count", r.count, m_count_now());
    chk("compare", r.compare, m_cmp);
    chk("status", r.status, m_status);
    chk("cause", r.cause, ca);
    chk("epc", r.epc, m_epc);
    chk("epc_out", bus.epc_out, m_epc);
    chk("int_pending", 32'(bus.int_pending),
        32'(m_status[0] & ~m_status[1] & |(ca[15:8] & m_status[15:8])));
    chk("cp0_flush", 32'(bus.cp0_flush), 32'(resetn & ~m_status[1] & |bus.exc_valid));
    case (bus.rsel)
      RS_BADVADDR: rd = m_bva;
      RS_COUNT:    rd = m_count_now();
      RS_COMPARE:  rd = m_cmp;
      RS_STATUS:   rd = m_status;
      RS_CAUSE:    rd = ca;
      RS_EPC:      rd = m_epc;
      default:     rd = '0;
    endcase
    chk("rdata", bus.rdata, rd);
  endtask

  task automatic step();
    #1 check_all();
    @(posedge clk);
    if (resetn) model_update(); else model_reset();
    @(negedge clk);
  endtask

  task automatic idle();
    bus.wen = '0; bus.wsel = '0; bus.wdata = '0; bus.exc_valid = '0;
    for (int i = 0; i < NPORT; i++) bus.exc_code[i] = INT;
    bus.exc_pc = '0; bus.exc_bd = '0; bus.exc_badvaddr = '0;
    bus.eret = 1'b0; bus.ext_int = '0;
  endtask

  function automatic logic [7:0] pick_sel();
    case ($urandom_range(0, 8))
      0: return RS_BADVADDR;
      1: return RS_COUNT;
      2: return RS_COMPARE;
      3: return RS_STATUS;
      4: return RS_CAUSE;
      5: return RS_EPC;
      6: return 8'h61;
      7: return 8'h00;
      default: return 8'hFF;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    bus.rsel = RS_COUNT;
    bus.exc_valid = 2'b11;
    resetn = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    chk("rst_count", bus.rdata, 32'd0);
    chk("rst_status", bus.cp0_reg.status, 32'd0);
    chk("rst_epc_out", bus.epc_out, 32'd0);
    chk("rst_int_pending", 32'(bus.int_pending), 32'd0);
    chk("rst_flush", 32'(bus.cp0_flush), 32'd0);
    @(negedge clk);
    idle();
    resetn = 1'b1;

    // Timer basics with TIMER_DIV=2.
    repeat (10) step();
    chk("count_after_10", bus.rdata, 32'd5);
    bus.wen = 2'b01; bus.wsel[0] = RS_COUNT; bus.wdata[0] = 32'hFFFF_FFFF;
    step();
    idle();
    chk("count_written", bus.rdata, 32'hFFFF_FFFF);
    repeat (2) step();
    chk("count_wrapped", bus.rdata, 32'd0);

    // Compare match interrupt.
    bus.wen = 2'b11;
    bus.wsel[0] = RS_STATUS; bus.wdata[0] = 32'h0000_8001;
    bus.wsel[1] = RS_COUNT;  bus.wdata[1] = 32'd6;
    step();
    idle();
    bus.wen = 2'b01; bus.wsel[0] = RS_COMPARE; bus.wdata[0] = 32'd8;
    step();
    idle();
    for (int n = 0; n < 20 && bus.rdata !== 32'd8; n++) step();
    chk("count_reaches_8", bus.rdata, 32'd8);
    chk("int_before_ti", 32'(bus.int_pending), 32'd0);
    step();
    chk("int_after_match", 32'(bus.int_pending), 32'd1);
    repeat (3) step();
    chk("int_sticky", 32'(bus.int_pending), 32'd1);
    bus.wen = 2'b01; bus.wsel[0] = RS_COMPARE; bus.wdata[0] = 32'd100;
    step();
    idle();
    chk("int_cleared", 32'(bus.int_pending), 32'd0);

    // Two-lane exception: lane 0 ADEL wins, lane 1 EPC write dropped.
    bus.exc_valid = 2'b11;
    bus.exc_code[0] = ADEL; bus.exc_badvaddr[0] = 32'h0000_1001; bus.exc_pc[0] = 32'h8000_0200;
    bus.exc_code[1] = SYS;  bus.exc_pc[1] = 32'h8000_0204;
    bus.wen = 2'b10; bus.wsel[1] = RS_EPC; bus.wdata[1] = 32'hDEAD_BEEF;
    #1 chk("flush_accept", 32'(bus.cp0_flush), 32'd1);
    step();
    idle();
    chk("exccode_adel", 32'(bus.cp0_reg.cause[6:2]), 32'd4);
    chk("badvaddr_1001", bus.cp0_reg.badvaddr, 32'h0000_1001);
    chk("epc_lane0", bus.cp0_reg.epc, 32'h8000_0200);
    chk("exl_set", 32'(bus.cp0_reg.status[1]), 32'd1);

    // Exception while EXL=1 is ignored; then ERET; then branch-delay entry.
    bus.exc_valid = 2'b01; bus.exc_code[0] = SYS; bus.exc_pc[0] = 32'h0000_1234;
    #1 chk("flush_ignored", 32'(bus.cp0_flush), 32'd0);
    step();
    idle();
    chk("epc_kept", bus.epc_out, 32'h8000_0200);
    bus.eret = 1'b1;
    step();
    idle();
    chk("eret_clears_exl", 32'(bus.cp0_reg.status[1]), 32'd0);
    bus.exc_valid = 2'b01; bus.exc_code[0] = SYS; bus.exc_pc[0] = 32'hBFC0_0104; bus.exc_bd[0] = 1'b1;
    step();
    idle();
    chk("epc_bd", bus.epc_out, 32'hBFC0_0100);
    chk("cause_bd", 32'(bus.cp0_reg.cause[31]), 32'd1);
    bus.eret = 1'b1;
    step();
    idle();

    // Interrupt synchroniser, then simultaneous eret and exception.
    bus.ext_int = 5'b00001;
    step();
    bus.ext_int = '0;
    chk("ip2_stage1", 32'(bus.cp0_reg.cause[10]), 32'd0);
    step();
    chk("ip2_synced", 32'(bus.cp0_reg.cause[10]), 32'd1);
    step();
    chk("ip2_dropped", 32'(bus.cp0_reg.cause[10]), 32'd0);
    bus.eret = 1'b1; bus.exc_valid = 2'b01; bus.exc_code[0] = OV; bus.exc_pc[0] = 32'h40;
    step();
    idle();
    chk("eret_exc_exl", 32'(bus.cp0_reg.status[1]), 32'd1);
    bus.eret = 1'b1;
    step();
    idle();

    // Asynchronous reset in mid-operation.
    repeat (3) step();
    bus.exc_valid = 2'b01;
    resetn = 1'b0;
    model_reset();
    #1;
    chk("async_rst_count", bus.rdata, 32'd0);
    chk("async_rst_epc", bus.epc_out, 32'd0);
    chk("async_rst_status", bus.cp0_reg.status, 32'd0);
    chk("async_rst_int", 32'(bus.int_pending), 32'd0);
    chk("async_rst_flush", 32'(bus.cp0_flush), 32'd0);
    step();
    idle();
    resetn = 1'b1;
    repeat (2) step();
    chk("presc_restart", bus.rdata, 32'd1);

    // Randomised traffic.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NPORT; i++) begin
        bus.wen[i]          = ($urandom_range(0, 3) == 0);
        bus.wsel[i]         = pick_sel();
        bus.wdata[i]        = $urandom;
        if (bus.wsel[i] == RS_COMPARE) bus.wdata[i] = m_count_now() + $urandom_range(0, 6);
        bus.exc_valid[i]    = ($urandom_range(0, 7) == 0);
        bus.exc_code[i]     = ecode_t'($urandom_range(0, 13));
        bus.exc_pc[i]       = $urandom;
        bus.exc_bd[i]       = $urandom_range(0, 1);
        bus.exc_badvaddr[i] = $urandom;
      end
      bus.eret    = ($urandom_range(0, 5) == 0);
      bus.ext_int = NHWINT'($urandom);
      bus.rsel    = pick_sel();
      if (c % 1000 == 999) begin
        resetn = 1'b0;
        model_reset();
        step();
        resetn = 1'b1;
      end else begin
        step();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
